// File: rtl/imem_readback_if.sv
// Bus bundle for the instruction-memory read-back engine: command channel,
// byte read port toward instruction memory, word output stream and status.
// The engine connects through the slave modport; the requester/bench through master.
interface imem_readback_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0]  cmd_count;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  logic              word_valid;
  logic              word_ready;
  logic [31:0]       word_data;
  logic [ADDR_W-1:0] word_addr;
  logic              word_last;

  logic              busy;
  logic              done;
  logic              err_unaligned;
  logic [31:0]       csum;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_count, mem_rdata, word_ready,
    output cmd_ready, mem_rd_en, mem_addr, word_valid, word_data, word_addr,
           word_last, busy, done, err_unaligned, csum
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_count, mem_rdata, word_ready,
    input  cmd_ready, mem_rd_en, mem_addr, word_valid, word_data, word_addr,
           word_last, busy, done, err_unaligned, csum
  );
endinterface

// File: rtl/imem_readback.sv
// Sequential read-back engine for the byte-addressed instruction memory.
// Accepts (addr, count), reads four bytes per word through a one-cycle
// synchronous read port, reassembles little-endian words and streams them out.
// Optional feature: define IMEM_READBACK_CSUM_EN to build the modulo-2^32
// word checksum; otherwise csum is tied to zero.
module imem_readback #(
  parameter int ADDR_W      = 32,
  parameter int BASE_OFFSET = 4,
  parameter int CNT_W       = 16
) (
  input logic           clock,
  input logic           reset,
  imem_readback_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  k_q;
  logic [1:0]        idx_q;     // byte lane being read this cycle
  logic [1:0]        rd_idx_q;  // byte lane whose data arrives this cycle
  logic              rd_q;      // a read was issued last cycle
  logic [31:0]       data_q;
  logic              err_q;

  logic              accept;
  logic              word_hs;
  logic              is_last;
  logic [ADDR_W-1:0] k_off;
  logic              rd_en;
  logic              word_valid;
  logic              done;

  assign accept  = (state_q == IDLE) && bus.cmd_valid;
  assign word_hs = (state_q == OUT) && bus.word_ready;
  assign is_last = (k_q == count_q - CNT_W'(1));
  assign k_off   = ADDR_W'({k_q, 2'b00});

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-state output decode.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    word_valid = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_addr[1:0] != 2'b00 || bus.cmd_count == '0) state_d = FIN;
          else                                                    state_d = ISSUE;
        end
      end
      ISSUE: begin
        rd_en = 1'b1;
        if (idx_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: state_d = OUT;
      OUT: begin
        word_valid = 1'b1;
        if (bus.word_ready) state_d = is_last ? FIN : ISSUE;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, byte/word counters and byte-lane capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      count_q  <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      rd_idx_q <= '0;
      rd_q     <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_q     <= rd_en;
      rd_idx_q <= idx_q;
      if (rd_q) data_q[{rd_idx_q, 3'b000} +: 8] <= bus.mem_rdata;
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        count_q <= bus.cmd_count;
        k_q     <= '0;
        idx_q   <= '0;
        err_q   <= (bus.cmd_addr[1:0] != 2'b00);
      end else if (state_q == ISSUE) begin
        idx_q <= idx_q + 2'd1;
      end else if (word_hs && !is_last) begin
        k_q <= k_q + CNT_W'(1);
      end
    end
  end

`ifdef IMEM_READBACK_CSUM_EN
  logic [31:0] csum_q;

  // Checksum of handshaked words; cleared on acceptance, held after done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       csum_q <= '0;
    else if (accept)  csum_q <= '0;
    else if (word_hs) csum_q <= csum_q + data_q;
  end

  assign bus.csum = csum_q;
`else
  assign bus.csum = '0;
`endif

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_rd_en     = rd_en;
  assign bus.mem_addr      = rd_en ? (addr_q + ADDR_W'(BASE_OFFSET) + k_off + ADDR_W'(idx_q))
                                   : '0;
  assign bus.word_valid    = word_valid;
  assign bus.word_data     = data_q;
  assign bus.word_addr     = addr_q + k_off;
  assign bus.word_last     = word_valid && is_last;
  assign bus.done          = done;
  assign bus.err_unaligned = done && err_q;

endmodule

// File: tb/tb_imem_readback.sv
// Directed self-checking bench for imem_readback: streaming, checksum,
// backpressure, unaligned and zero-count commands, and mid-operation reset.
module tb_imem_readback;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  imem_readback_if #(.ADDR_W(32), .CNT_W(16)) bus ();

  imem_readback #(.ADDR_W(32), .BASE_OFFSET(4), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // One-cycle synchronous byte memory model.
  logic [7:0] mem [0:255];
  always @(posedge clock) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[7:0]];

  logic [31:0] exp_words [0:7];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_rd_en"},     32'(bus.mem_rd_en), 32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
    check({tag, "_wvalid"},    32'(bus.word_valid), 32'd0);
    check({tag, "_wdata"},     bus.word_data, 32'd0);
    check({tag, "_waddr"},     bus.word_addr, 32'd0);
    check({tag, "_wlast"},     32'(bus.word_last), 32'd0);
    check({tag, "_busy"},      32'(bus.busy), 32'd0);
    check({tag, "_done"},      32'(bus.done), 32'd0);
    check({tag, "_err"},       32'(bus.err_unaligned), 32'd0);
    check({tag, "_csum"},      bus.csum, 32'd0);
  endtask

  task automatic load_words(input int n);
    for (int w = 0; w < n; w++)
      for (int b = 0; b < 4; b++)
        mem[4 + 4*w + b] = exp_words[w][8*b +: 8];
  endtask

  function automatic logic [31:0] exp_csum(input int n);
    logic [31:0] s = 32'd0;
`ifdef IMEM_READBACK_CSUM_EN
    for (int w = 0; w < n; w++) s = s + exp_words[w];
`endif
    return s;
  endfunction

  // Offers one command; returns at the sampling point of cycle 1.
  task automatic issue(input logic [31:0] a, input logic [15:0] n);
    @(negedge clock);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_addr  = a;
    bus.cmd_count = n;
    bus.cmd_valid = 1'b1;
    @(negedge clock);
    bus.cmd_valid = 1'b0;
  endtask

  // Streams n words from address a; holds word_ready low for stall_n
  // cycles while word stall_w is offered.
  task automatic run_words(input logic [31:0] a, input int n, input int stall_w, input int stall_n);
    int w = 0, rd = 0, stall = 0, hs_cyc = 0, first_valid = -1;
    bit done_seen = 0, prev_rd = 0, prev_valid = 0;
    logic [31:0] sum_at_done = '0;
    bus.word_ready = 1'b1;
    issue(a, 16'(n));
    for (int cyc = 1; cyc < 60*n + 40 && !done_seen; cyc++) begin
      if (cyc > 1) @(negedge clock);
      bus.word_ready = 1'b1;
      if (bus.word_valid && w == stall_w && stall < stall_n) begin
        bus.word_ready = 1'b0;
        stall++;
        check("bp_hold_data", bus.word_data, exp_words[w]);
        check("bp_rd_en", 32'(bus.mem_rd_en), 32'd0);
      end
      if (bus.mem_rd_en) begin
        if (rd == 0) check("first_rd_cycle", cyc, 32'd1);
        if (!prev_rd && w > 0) check("rd_after_hs", cyc, hs_cyc + 1);
        check("mem_addr", bus.mem_addr, a + 32'd4 + 32'(4*w) + 32'(rd % 4));
        rd++;
      end
      if (bus.word_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (!prev_valid && w > 0) check("valid_after_hs", cyc, hs_cyc + 6);
        if (bus.word_ready) begin
          check("word_data", bus.word_data, exp_words[w]);
          check("word_addr", bus.word_addr, a + 32'(4*w));
          check("word_last", 32'(bus.word_last), 32'(w == n-1));
          hs_cyc = cyc;
          w++;
        end
      end
      if (bus.done) begin
        done_seen = 1;
        check("done_cycle", cyc, hs_cyc + 1);
        check("done_err", 32'(bus.err_unaligned), 32'd0);
        check("csum_at_done", bus.csum, exp_csum(n));
        sum_at_done = bus.csum;
      end
      prev_rd    = bus.mem_rd_en;
      prev_valid = bus.word_valid;
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    check("first_valid_cycle", first_valid, 32'd6);
    check("word_count", w, n);
    check("read_count", rd, 4*n);
    @(negedge clock);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_after_done", 32'(bus.cmd_ready), 32'd1);
    check("csum_held", bus.csum, exp_csum(n));
  endtask

  // Unaligned or zero-count command: done in cycle 1, no reads, no words.
  task automatic run_noread(input logic [31:0] a, input logic [15:0] n, input logic exp_err, input string tag);
    bus.word_ready = 1'b1;
    issue(a, n);
    check({tag, "_done_c1"}, 32'(bus.done), 32'd1);
    check({tag, "_err_c1"},  32'(bus.err_unaligned), 32'(exp_err));
    check({tag, "_busy_c1"}, 32'(bus.busy), 32'd1);
    check({tag, "_rd_c1"},   32'(bus.mem_rd_en), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check({tag, "_no_rd"},    32'(bus.mem_rd_en), 32'd0);
      check({tag, "_no_valid"}, 32'(bus.word_valid), 32'd0);
      check({tag, "_no_done"},  32'(bus.done), 32'd0);
    end
    check({tag, "_idle"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    bit found = 0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_count  = '0;
    bus.word_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    exp_words[0] = 32'h01000f93; exp_words[1] = 32'hffe00513;
    exp_words[2] = 32'h00300593; exp_words[3] = 32'h01000f13;
    exp_words[4] = 32'h00b57463; exp_words[5] = 32'h00900f13;
    exp_words[6] = 32'h0ff00e93; exp_words[7] = 32'h00000000;
    load_words(7);

    // Reset state; a command offered during reset is not taken.
    bus.cmd_valid = 1'b1;
    bus.cmd_count = 16'd1;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    bus.cmd_valid = 1'b0;
    reset = 1'b1;

    // Seven-word program read with word_ready held high.
    run_words(32'd0, 7, -1, 0);

    // Checksum wrap: 1 + 0xFFFFFFFF.
    exp_words[0] = 32'h00000001;
    exp_words[1] = 32'hFFFFFFFF;
    load_words(2);
    run_words(32'd0, 2, -1, 0);

    // Backpressure on word 1 for ten cycles.
    exp_words[0] = 32'h01000f93;
    exp_words[1] = 32'hffe00513;
    load_words(7);
    run_words(32'd0, 7, 1, 10);

    run_noread(32'h2, 16'd3, 1'b1, "unaligned");
    run_noread(32'h0, 16'd0, 1'b0, "zero_count");

    // Reset during the ISSUE phase of word 2.
    bus.word_ready = 1'b1;
    issue(32'd0, 16'd7);
    for (int cyc = 1; cyc < 40 && !found; cyc++) begin
      if (cyc > 1) @(negedge clock);
      if (bus.mem_rd_en && bus.mem_addr == 32'd13) found = 1;
    end
    check("reset_setup_found", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_vals("mid_rst");
    bus.cmd_valid = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_no_accept", 32'(bus.busy), 32'd0);
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check("rst_no_done", 32'(bus.done), 32'd0);
    end
    run_words(32'd0, 1, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
